// File: rtl/out_mem_pkg.sv
// Shared types and widths for the output-accumulator controller.
package out_mem_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } accum_state_e;

    // S1 control: op captured at acceptance
    typedef struct packed {
        logic              valid;
        logic              clear;
        logic [ADDR_W-1:0] addr;
    } stage_ctrl_t;

    // S2/S3 control: pending and last-committed write
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } wr_ctrl_t;

endpackage

// File: rtl/accum_lane.sv
// One accumulator lane: forward mux, adder and S1/S2/S3 data registers.
// Define SATURATE_EN to clamp signed overflow instead of wrapping.
module accum_lane #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_load,
    input  logic signed [DATA_WIDTH-1:0] i_psum,
    input  logic                         i_s1_valid,
    input  logic                         i_s1_clear,
    input  logic                         i_s2_valid,
    input  logic                         i_s2_hit,
    input  logic                         i_s2_mask,
    input  logic                         i_s3_hit,
    input  logic                         i_s3_mask,
    input  logic signed [DATA_WIDTH-1:0] i_rd_data,
    output logic signed [DATA_WIDTH-1:0] o_s2_data
);

    logic signed [DATA_WIDTH-1:0] r_s1_psum;
    logic signed [DATA_WIDTH-1:0] r_s2_data;
    logic signed [DATA_WIDTH-1:0] r_s3_data;
    logic signed [DATA_WIDTH-1:0] w_src;
    logic signed [DATA_WIDTH-1:0] w_base;
    logic signed [DATA_WIDTH-1:0] w_sum;

    // Newest in-flight value for this row wins over the SRAM read
    always_comb begin
        w_src = i_rd_data;
        if (i_s2_hit && i_s2_mask) begin
            w_src = r_s2_data;
        end else if (i_s3_hit && i_s3_mask) begin
            w_src = r_s3_data;
        end
        w_base = i_s1_clear ? '0 : w_src;
    end

`ifdef SATURATE_EN
    logic [DATA_WIDTH:0] w_wide;

    always_comb begin
        w_wide = {w_base[DATA_WIDTH-1], w_base} + {r_s1_psum[DATA_WIDTH-1], r_s1_psum};
        if (w_wide[DATA_WIDTH] != w_wide[DATA_WIDTH-1]) begin
            w_sum = w_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            w_sum = w_wide[DATA_WIDTH-1:0];
        end
    end
`else
    assign w_sum = w_base + r_s1_psum;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_psum <= '0;
            r_s2_data <= '0;
            r_s3_data <= '0;
        end else begin
            if (i_load) begin
                r_s1_psum <= i_psum;
            end
            if (i_s1_valid) begin
                r_s2_data <= w_sum;
            end
            if (i_s2_valid) begin
                r_s3_data <= r_s2_data;
            end
        end
    end

    assign o_s2_data = r_s2_data;

endmodule

// File: rtl/out_accum_ctrl.sv
// Read-modify-write accumulator in front of the per-row output SRAMs, with a
// valid/ready drain path. Lane adders honour SATURATE_EN.
module out_accum_ctrl
    import out_mem_pkg::*;
#(
    parameter int unsigned ACCUM_ROW  = 256,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         psum_valid,
    output logic                         psum_ready,
    input  logic [ACCUM_ROW-1:0]         psum_row_en,
    input  logic signed [DATA_WIDTH-1:0] psum_data   [0:ACCUM_ROW-1],
    input  logic [ADDR_W-1:0]            psum_addr,
    input  logic                         psum_clear,
    input  logic                         drain_start,
    input  logic [ADDR_W:0]              drain_len,
    output logic                         drain_done,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data    [0:ACCUM_ROW-1],
    output logic [ADDR_W-1:0]            out_addr,
    output logic [ACCUM_ROW-1:0]         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_rd_addr [0:ACCUM_ROW-1],
    input  logic signed [DATA_WIDTH-1:0] mem_rd_data [0:ACCUM_ROW-1],
    output logic [ACCUM_ROW-1:0]         mem_wr_en,
    output logic [ADDR_W-1:0]            mem_wr_addr [0:ACCUM_ROW-1],
    output logic signed [DATA_WIDTH-1:0] mem_wr_data [0:ACCUM_ROW-1]
);

    accum_state_e         r_state;
    accum_state_e         w_state_nxt;
    stage_ctrl_t          r_s1;
    wr_ctrl_t             r_s2;
    wr_ctrl_t             r_s3;
    logic [ACCUM_ROW-1:0] r_s1_mask;
    logic [ACCUM_ROW-1:0] r_s2_mask;
    logic [ACCUM_ROW-1:0] r_s3_mask;
    logic [CNT_W-1:0]     r_k;
    logic [CNT_W-1:0]     r_len;
    logic                 r_out_valid;
    logic [ADDR_W-1:0]    r_out_addr;
    logic                 r_drain_done;
    logic                 w_accept;
    logic                 w_issue;
    logic                 w_last_hs;
    logic                 w_s2_hit;
    logic                 w_s3_hit;
    logic                 w_start_idle;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (drain_start && (drain_len != '0)) w_state_nxt = FLUSH;
            FLUSH:   if (!r_s1.valid && !r_s2.valid) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        psum_ready = 1'b0;
        w_issue    = 1'b0;
        w_last_hs  = 1'b0;
        case (r_state)
            IDLE:  psum_ready = 1'b1;
            DRAIN: begin
                w_issue   = (r_k < r_len) && (!r_out_valid || out_ready);
                w_last_hs = r_out_valid && out_ready && (r_k == r_len);
            end
            default: ;
        endcase
    end

    assign w_accept     = psum_valid && psum_ready;
    assign w_start_idle = (r_state == IDLE) && drain_start;
    assign w_s2_hit     = r_s2.valid && (r_s2.addr == r_s1.addr);
    assign w_s3_hit     = r_s3.valid && (r_s3.addr == r_s1.addr);
    assign busy         = (r_state != IDLE) || r_s1.valid || r_s2.valid;

    // Shared stage control; S3 keeps the most recent committed write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_s1_mask <= '0;
            r_s2_mask <= '0;
            r_s3_mask <= '0;
        end else begin
            r_s1.valid <= w_accept;
            if (w_accept) begin
                r_s1.clear <= psum_clear;
                r_s1.addr  <= psum_addr;
                r_s1_mask  <= psum_row_en;
            end
            r_s2.valid <= r_s1.valid;
            r_s2.addr  <= r_s1.addr;
            r_s2_mask  <= r_s1_mask;
            if (r_s2.valid) begin
                r_s3      <= r_s2;
                r_s3_mask <= r_s2_mask;
            end
        end
    end

    // Drain counter and beat register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_k          <= '0;
            r_len        <= '0;
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_drain_done <= 1'b0;
        end else begin
            r_drain_done <= w_last_hs || (w_start_idle && (drain_len == '0));
            if (w_start_idle) begin
                r_len <= drain_len;
                r_k   <= '0;
            end
            if (w_issue) begin
                r_k         <= r_k + CNT_W'(1);
                r_out_valid <= 1'b1;
                r_out_addr  <= r_k[ADDR_W-1:0];
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_addr   = r_out_addr;
    assign drain_done = r_drain_done;

    for (genvar i = 0; i < int'(ACCUM_ROW); i++) begin : g_lane
        assign mem_rd_en[i]   = w_issue || (w_accept && !psum_clear && psum_row_en[i]);
        assign mem_rd_addr[i] = (r_state == DRAIN) ? r_k[ADDR_W-1:0] : psum_addr;
        assign mem_wr_en[i]   = r_s2.valid && r_s2_mask[i];
        assign mem_wr_addr[i] = r_s2.addr;
        assign out_data[i]    = mem_rd_data[i];

        accum_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rstn       (rstn),
            .i_load     (w_accept),
            .i_psum     (psum_data[i]),
            .i_s1_valid (r_s1.valid),
            .i_s1_clear (r_s1.clear),
            .i_s2_valid (r_s2.valid),
            .i_s2_hit   (w_s2_hit),
            .i_s2_mask  (r_s2_mask[i]),
            .i_s3_hit   (w_s3_hit),
            .i_s3_mask  (r_s3_mask[i]),
            .i_rd_data  (mem_rd_data[i]),
            .o_s2_data  (mem_wr_data[i])
        );
    end

endmodule
